// File: rtl/knap_multi_seq_eval.sv
// knap_multi_seq_eval: sequential multi-constraint knapsack checker.
// One item per handshake is accumulated into saturating value/weight/volume
// totals. The final totals are compared against the thresholds latched at
// job start, and done pulses for one cycle when the result is ready.
module knap_multi_seq_eval #(
    parameter int N_ITEMS = 19,
    parameter int CW      = 9,
    parameter int AW      = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] cfg_min_value,
    input  logic [AW-1:0] cfg_max_weight,
    input  logic [AW-1:0] cfg_max_volume,
    input  logic          item_valid,
    output logic          item_ready,
    input  logic          item_sel,
    input  logic [CW-1:0] item_value,
    input  logic [CW-1:0] item_weight,
    input  logic [CW-1:0] item_volume,
    output logic          busy,
    output logic          done,
    output logic          valid,
    output logic [AW-1:0] total_value,
    output logic [AW-1:0] total_weight,
    output logic [AW-1:0] total_volume,
    output logic          overflow
);

    localparam int CNTW = (N_ITEMS < 2) ? 1 : $clog2(N_ITEMS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CNTW-1:0] item_count;
    logic [AW-1:0]   min_value;
    logic [AW-1:0]   max_weight;
    logic [AW-1:0]   max_volume;

    logic            handshake;
    logic            last_beat;
    logic [AW:0]     next_value;
    logic [AW:0]     next_weight;
    logic [AW:0]     next_volume;
    logic            next_overflow;
    logic            next_valid;

    // Adds a zero-extended coefficient; bit AW of the result flags saturation
    // and the low AW bits then hold the clamped maximum.
    function automatic logic [AW:0] sat_add(input logic [AW-1:0] acc,
                                            input logic [CW-1:0] coef);
        logic [AW:0] sum;
        sum = {1'b0, acc} + (AW+1)'(coef);
        if (sum[AW]) begin
            sum = {1'b1, {AW{1'b1}}};
        end
        return sum;
    endfunction

    // Both outputs are decoded straight from the state register, so they are
    // glitch-free and change only on a clock edge.
    assign item_ready = (state == ACCUM);
    assign busy       = (state == ACCUM);
    assign handshake  = item_valid && item_ready;
    assign last_beat  = handshake && (item_count == CNTW'(N_ITEMS - 1));

    // Next-total, overflow and verdict computation for the current beat.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        next_value  = {1'b0, total_value};
        next_weight = {1'b0, total_weight};
        next_volume = {1'b0, total_volume};
        if (item_sel) begin
            next_value  = sat_add(total_value,  item_value);
            next_weight = sat_add(total_weight, item_weight);
            next_volume = sat_add(total_volume, item_volume);
        end
        next_overflow = overflow | next_value[AW] | next_weight[AW] | next_volume[AW];
        next_valid    = (next_value[AW-1:0]  >= min_value)  &&
                        (next_weight[AW-1:0] <= max_weight) &&
                        (next_volume[AW-1:0] <= max_volume);
    end

    // Job control FSM with registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            item_count   <= '0;
            min_value    <= '0;
            max_weight   <= '0;
            max_volume   <= '0;
            done         <= 1'b0;
            valid        <= 1'b0;
            total_value  <= '0;
            total_weight <= '0;
            total_volume <= '0;
            overflow     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here update from pre-edge values, regardless of statement order.
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= ACCUM;
                        item_count   <= '0;
                        min_value    <= cfg_min_value;
                        max_weight   <= cfg_max_weight;
                        max_volume   <= cfg_max_volume;
                        valid        <= 1'b0;
                        total_value  <= '0;
                        total_weight <= '0;
                        total_volume <= '0;
                        overflow     <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (handshake) begin
                        item_count   <= item_count + 1'b1;
                        total_value  <= next_value[AW-1:0];
                        total_weight <= next_weight[AW-1:0];
                        total_volume <= next_volume[AW-1:0];
                        overflow     <= next_overflow;
                        if (last_beat) begin
                            state <= DONE;
                            done  <= 1'b1;
                            valid <= next_valid;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knap_multi_seq_eval.sv
// Self-checking bench for knap_multi_seq_eval: a default (AW=12) instance and
// a narrow (AW=9) instance share the item stream; each job is checked against
// a reference model that sums selected coefficients and clamps at 2^AW-1.
module tb_knap_multi_seq_eval;

    localparam int N = 19;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start9 = 1'b0;
    logic [11:0] cfg_min = '0, cfg_maxw = '0, cfg_maxv = '0;
    logic [8:0]  cfg9_min = '0, cfg9_maxw = '0, cfg9_maxv = '0;
    logic        item_valid = 1'b0;
    logic        item_sel = 1'b0;
    logic [8:0]  item_value = '0, item_weight = '0, item_volume = '0;

    logic        ready, busy, done, valid, ovf;
    logic [11:0] tv, tw, tvol;
    logic        ready9, busy9, done9, valid9, ovf9;
    logic [8:0]  tv9, tw9, tvol9;

    int n_cmp = 0;
    int n_bad = 0;

    // Item table: selection bits and coefficients [0]=value [1]=weight [2]=volume.
    int it_sel [N];
    int it_coef[3][N];
    bit use9 = 1'b0;

    knap_multi_seq_eval dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_min_value(cfg_min), .cfg_max_weight(cfg_maxw), .cfg_max_volume(cfg_maxv),
        .item_valid(item_valid), .item_ready(ready), .item_sel(item_sel),
        .item_value(item_value), .item_weight(item_weight), .item_volume(item_volume),
        .busy(busy), .done(done), .valid(valid),
        .total_value(tv), .total_weight(tw), .total_volume(tvol), .overflow(ovf)
    );

    knap_multi_seq_eval #(.N_ITEMS(N), .CW(9), .AW(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9),
        .cfg_min_value(cfg9_min), .cfg_max_weight(cfg9_maxw), .cfg_max_volume(cfg9_maxv),
        .item_valid(item_valid), .item_ready(ready9), .item_sel(item_sel),
        .item_value(item_value), .item_weight(item_weight), .item_volume(item_volume),
        .busy(busy9), .done(done9), .valid(valid9),
        .total_value(tv9), .total_weight(tw9), .total_volume(tvol9), .overflow(ovf9)
    );

    always #5 clk = ~clk;

    // Outputs of whichever instance the current job targets.
    logic        c_ready, c_busy, c_done, c_valid, c_ovf;
    logic [11:0] c_tv, c_tw, c_tvol;
    assign c_ready = use9 ? ready9 : ready;
    assign c_busy  = use9 ? busy9  : busy;
    assign c_done  = use9 ? done9  : done;
    assign c_valid = use9 ? valid9 : valid;
    assign c_ovf   = use9 ? ovf9   : ovf;
    assign c_tv    = use9 ? {3'b0, tv9}   : tv;
    assign c_tw    = use9 ? {3'b0, tw9}   : tw;
    assign c_tvol  = use9 ? {3'b0, tvol9} : tvol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raw (unclamped) sum of one field over the first k items.
    function automatic int raw_sum(input int field, input int k);
        int s = 0;
        for (int i = 0; i < k; i++) if (it_sel[i] != 0) s += it_coef[field][i];
        return s;
    endfunction

    function automatic int sat_sum(input int field, input int k, input int lim);
        int s = raw_sum(field, k);
        return (s > lim) ? lim : s;
    endfunction

    task automatic clear_items();
        for (int i = 0; i < N; i++) begin
            it_sel[i] = 0;
            for (int f = 0; f < 3; f++) it_coef[f][i] = $urandom_range(0, 511);
        end
    endtask

    task automatic put_item(input int idx, input int v, input int w, input int vol);
        it_sel[idx] = 1;
        it_coef[0][idx] = v;
        it_coef[1][idx] = w;
        it_coef[2][idx] = vol;
    endtask

    task automatic drive_start(input bit v);
        if (use9) start9 = v; else start = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tv"}, tv, 0);     check({tag, "_tw"}, tw, 0);
        check({tag, "_tvol"}, tvol, 0); check({tag, "_flags"}, {ready, busy, done, valid, ovf}, 0);
        check({tag, "_tv9"}, tv9, 0);   check({tag, "_tw9"}, tw9, 0);
        check({tag, "_tvol9"}, tvol9, 0); check({tag, "_flags9"}, {ready9, busy9, done9, valid9, ovf9}, 0);
    endtask

    // Runs one job; called just after a negedge, returns just after the negedge
    // on which done is expected (or after the abort sequence).
    task automatic run_job(input string tag, input bit sel9, input int minv, input int maxw,
                           input int maxv, input bit gaps, input bit mid_start, input int abort_at);
        int lim;
        int tries;
        int n_gap;
        use9 = sel9;
        lim = sel9 ? 511 : 4095;
        cfg_min = 12'(minv);  cfg_maxw = 12'(maxw);  cfg_maxv = 12'(maxv);
        cfg9_min = 9'(minv);  cfg9_maxw = 9'(maxw);  cfg9_maxv = 9'(maxv);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        check({tag, "_busy"}, c_busy, 1);
        check({tag, "_clear"}, {c_tv, c_tw, c_tvol, c_ovf}, 0);
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, "_abort"});
                @(negedge clk);
                rst_n = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check({tag, "_nodone"}, {done, done9, busy, busy9}, 0);
                end
                return;
            end
            n_gap = gaps ? $urandom_range(0, 3) : 0;
            if (mid_start && i == 5 && n_gap == 0) n_gap = 1;
            for (int g = 0; g < n_gap; g++) begin
                item_valid = 1'b0;
                item_sel = ($urandom_range(0, 1) != 0);
                item_value = 9'($urandom);
                drive_start(mid_start && i == 5 && g == 0);
                @(negedge clk);
                drive_start(1'b0);
            end
            check({tag, "_early_done"}, c_done, 0);
            item_valid = 1'b1;
            item_sel = (it_sel[i] != 0);
            item_value = 9'(it_coef[0][i]);
            item_weight = 9'(it_coef[1][i]);
            item_volume = 9'(it_coef[2][i]);
            tries = 0;
            while (c_ready !== 1'b1 && tries < 50) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 50) begin
                check({tag, "_ready_timeout"}, c_ready, 1);
                item_valid = 1'b0;
                return;
            end
            @(negedge clk);
            item_valid = 1'b0;
            check({tag, "_prefix_tv"}, c_tv, sat_sum(0, i + 1, lim));
        end
        check({tag, "_done"}, c_done, 1);
        check({tag, "_tv"}, c_tv, sat_sum(0, N, lim));
        check({tag, "_tw"}, c_tw, sat_sum(1, N, lim));
        check({tag, "_tvol"}, c_tvol, sat_sum(2, N, lim));
        check({tag, "_ovf"}, c_ovf, (raw_sum(0, N) > lim) || (raw_sum(1, N) > lim) ||
                                    (raw_sum(2, N) > lim));
        check({tag, "_valid"}, c_valid, (sat_sum(0, N, lim) >= minv) &&
                                        (sat_sum(1, N, lim) <= maxw) &&
                                        (sat_sum(2, N, lim) <= maxv));
        check({tag, "_idle_ready"}, {c_ready, c_busy}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("post_reset");

        // All items unselected: totals stay zero, value constraint fails.
        clear_items();
        run_job("none_sel", 1'b0, 120, 60, 60, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("hold_valid", valid, 0);

        // K S G D M H: 127/39/70, volume fails; restarted straight from DONE below.
        clear_items();
        put_item(0, 30, 5, 5);   put_item(3, 29, 1, 28);  put_item(6, 18, 6, 4);
        put_item(9, 20, 18, 4);  put_item(12, 16, 8, 9);  put_item(18, 14, 1, 20);
        run_job("ksgdmh", 1'b0, 120, 60, 60, 1'b0, 1'b0, -1);
        it_sel[18] = 0;
        run_job("drop_h", 1'b0, 120, 60, 60, 1'b0, 1'b0, -1);
        put_item(18, 15, 0, 15);
        run_job("with_j", 1'b0, 120, 60, 60, 1'b0, 1'b0, -1);
        run_job("with_j_v65", 1'b0, 120, 60, 65, 1'b0, 1'b0, -1);

        // Same selection with stalls and an ignored start in mid-job.
        run_job("gaps_j_v65", 1'b0, 120, 60, 65, 1'b1, 1'b1, -1);

        // Narrow accumulator: value saturates at 511 and never wraps.
        for (int i = 0; i < N; i++) put_item(i, 511, $urandom_range(0, 40), $urandom_range(0, 40));
        run_job("sat9", 1'b1, 100, 511, 511, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("sat9_hold_tv", tv9, 511);

        // Random jobs with gaps on the wide instance.
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < N; i++) begin
                it_sel[i] = $urandom_range(0, 1);
                for (int f = 0; f < 3; f++)
                    it_coef[f][i] = (j < 3) ? $urandom_range(0, 60) : $urandom_range(0, 511);
            end
            run_job("rand", 1'b0, $urandom_range(100, 400), $urandom_range(100, 400),
                    $urandom_range(100, 4095), 1'b1, 1'b0, -1);
        end

        // Reset in the middle of a job, then a clean job to show recovery.
        run_job("abort", 1'b0, 120, 60, 60, 1'b1, 1'b0, 10);
        run_job("recover", 1'b0, 120, 60, 60, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
